// File: rtl/cyclic_encoder_7_4_pkg.sv
// -----------------------------------------------------------------------------
// cyclic_encoder_7_4_pkg
// Shared definitions for the (7,4) cyclic code encoder and its decoder.
// Contents:
//   CODE_N / CODE_K / CODE_M   : codeword, message and parity lengths
//   GEN_POLY_DEFAULT           : g(x) = x^3 + x + 1, coefficients x^3..x^0
//   enc_state_e                : encoder FSM states (IDLE, MSG, PAR)
//   lfsr3_step()               : one step of the 3-bit division LFSR
// -----------------------------------------------------------------------------
package cyclic_encoder_7_4_pkg;

  localparam int CODE_N = 7;
  localparam int CODE_K = 4;
  localparam int CODE_M = 3;

  localparam logic [3:0] GEN_POLY_DEFAULT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } enc_state_e;

  // One shift of the remainder LFSR. With gate_fb low the feedback is forced
  // to zero, which turns the register into a plain left shift used to flush
  // the parity bits out through q[2].
  function automatic logic [2:0] lfsr3_step(
    input logic [2:0] q,
    input logic       din,
    input logic       gate_fb,
    input logic [3:0] gen
  );
    logic fb;
    fb = gate_fb & (din ^ q[2]);
    return {q[1] ^ (fb & gen[2]),
            q[0] ^ (fb & gen[1]),
            fb & gen[0]};
  endfunction

endpackage

// File: rtl/cyclic_encoder_7_4_lfsr3.sv
// -----------------------------------------------------------------------------
// cyclic_lfsr3
// 3-bit Galois LFSR computing the remainder modulo g(x); shared by the
// encoder parity stage and the decoder syndrome stage.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears q
//   clr      : synchronous clear (has priority over shift)
//   shift    : advance the register by one bit
//   din      : serial input bit
//   gate_fb  : 1 = divide by g(x), 0 = plain shift with zero feedback
//   q[2:0]   : remainder register, q[2] is the highest-degree coefficient
// -----------------------------------------------------------------------------
module cyclic_lfsr3
  import cyclic_encoder_7_4_pkg::*;
#(
  parameter logic [3:0] GEN_POLY = GEN_POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift,
  input  logic       din,
  input  logic       gate_fb,
  output logic [2:0] q
);

  logic [2:0] q_r;
  logic [2:0] q_next_s;

  // Next remainder: clear, step, or hold.
  always_comb begin
    q_next_s = q_r;
    if (clr) begin
      q_next_s = 3'b000;
    end else if (shift) begin
      q_next_s = lfsr3_step(q_r, din, gate_fb, GEN_POLY);
    end else begin
      q_next_s = q_r;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 3'b000;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/cyclic_encoder_7_4.sv
// -----------------------------------------------------------------------------
// cyclic_encoder_7_4
// Serial systematic (7,4) cyclic encoder. A 4-bit message is accepted with a
// valid/ready handshake and emitted MSB first as m3 m2 m1 m0 p2 p1 p0, where
// p = m(x)*x^3 mod g(x). The serial output uses a valid/ready handshake and
// stalls cleanly when sout_ready is low.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   msg_data   : message, bit 3 is the x^3 coefficient
//   msg_valid  : msg_data valid
//   msg_ready  : encoder accepts a message this cycle
//   sout       : serial codeword bit
//   sout_valid : sout valid
//   sout_ready : downstream accepts sout
//   sout_last  : final parity bit of the codeword
//   busy       : a codeword is in flight
// -----------------------------------------------------------------------------
module cyclic_encoder_7_4
  import cyclic_encoder_7_4_pkg::*;
#(
  parameter logic [3:0] GEN_POLY = GEN_POLY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  msg_data,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        sout,
  output logic        sout_valid,
  input  logic        sout_ready,
  output logic        sout_last,
  output logic        busy
);

  enc_state_e        state_r;
  enc_state_e        state_next_s;
  logic [1:0]        cnt_r;
  logic [1:0]        cnt_next_s;
  logic [CODE_K-1:0] msg_r;
  logic [CODE_K-1:0] msg_next_s;

  logic [2:0]        lfsr_q_s;
  logic [2:0]        lfsr_next_s;
  logic              lfsr_clr_s;
  logic              lfsr_shift_s;
  logic              lfsr_din_s;
  logic              lfsr_gate_s;

  logic              xfer_s;
  logic              accept_s;
  logic              msg_ready_s;

  logic              sout_r;
  logic              sout_valid_r;
  logic              sout_last_r;
  logic              busy_r;
  logic              sout_next_s;

  // A bit moves downstream whenever a codeword is in flight and the sink is
  // ready. msg_ready has to follow sout_ready in the same cycle so that the
  // next message can be taken on the final parity transfer without a bubble.
  always_comb begin
    xfer_s      = 1'b0;
    msg_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        xfer_s      = 1'b0;
        msg_ready_s = 1'b1;
      end
      MSG: begin
        xfer_s      = sout_ready;
        msg_ready_s = 1'b0;
      end
      PAR: begin
        xfer_s      = sout_ready;
        msg_ready_s = (cnt_r == 2'd2) & sout_ready;
      end
      default: begin
        xfer_s      = 1'b0;
        msg_ready_s = 1'b0;
      end
    endcase
  end

  assign accept_s = msg_valid & msg_ready_s;

  // Next-state, counter, message register and LFSR control.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    msg_next_s   = msg_r;
    lfsr_clr_s   = 1'b0;
    lfsr_shift_s = 1'b0;
    lfsr_din_s   = msg_r[CODE_K-1];
    lfsr_gate_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = MSG;
          cnt_next_s   = 2'd0;
          msg_next_s   = msg_data;
          lfsr_clr_s   = 1'b1;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = 2'd0;
        end
      end
      MSG: begin
        if (xfer_s) begin
          lfsr_shift_s = 1'b1;
          lfsr_gate_s  = 1'b1;
          msg_next_s   = {msg_r[CODE_K-2:0], 1'b0};
          if (cnt_r == 2'd3) begin
            state_next_s = PAR;
            cnt_next_s   = 2'd0;
          end else begin
            cnt_next_s   = cnt_r + 2'd1;
          end
        end else begin
          state_next_s = MSG;
        end
      end
      PAR: begin
        if (xfer_s) begin
          // Zero feedback: the remainder simply shifts out through q[2].
          lfsr_shift_s = 1'b1;
          lfsr_gate_s  = 1'b0;
          if (cnt_r == 2'd2) begin
            cnt_next_s = 2'd0;
            if (accept_s) begin
              state_next_s = MSG;
              msg_next_s   = msg_data;
              lfsr_clr_s   = 1'b1;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            cnt_next_s = cnt_r + 2'd1;
          end
        end else begin
          state_next_s = PAR;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 2'd0;
        msg_next_s   = 4'b0000;
        lfsr_clr_s   = 1'b1;
      end
    endcase
  end

  cyclic_lfsr3 #(
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (lfsr_clr_s),
    .shift   (lfsr_shift_s),
    .din     (lfsr_din_s),
    .gate_fb (lfsr_gate_s),
    .q       (lfsr_q_s)
  );

  // Look-ahead of the LFSR contents so that sout can be registered: it is the
  // value the sub-module will hold after this edge.
  always_comb begin
    lfsr_next_s = lfsr_q_s;
    if (lfsr_clr_s) begin
      lfsr_next_s = 3'b000;
    end else if (lfsr_shift_s) begin
      lfsr_next_s = lfsr3_step(lfsr_q_s, lfsr_din_s, lfsr_gate_s, GEN_POLY);
    end else begin
      lfsr_next_s = lfsr_q_s;
    end
  end

  // Serial bit that will be presented after this edge.
  always_comb begin
    sout_next_s = 1'b0;
    case (state_next_s)
      MSG:     sout_next_s = msg_next_s[CODE_K-1];
      PAR:     sout_next_s = lfsr_next_s[2];
      IDLE:    sout_next_s = 1'b0;
      default: sout_next_s = 1'b0;
    endcase
  end

  // FSM state, bit counter and message shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      msg_r   <= 4'b0000;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      msg_r   <= msg_next_s;
    end
  end

  // Registered serial-side outputs; with no transfer every input to these
  // holds, so the outputs freeze while sout_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      sout_last_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      sout_r       <= sout_next_s;
      sout_valid_r <= (state_next_s != IDLE);
      sout_last_r  <= (state_next_s == PAR) && (cnt_next_s == 2'd2);
      busy_r       <= (state_next_s != IDLE);
    end
  end

  assign msg_ready  = msg_ready_s;
  assign sout       = sout_r;
  assign sout_valid = sout_valid_r;
  assign sout_last  = sout_last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cyclic_encoder_7_4.sv
// -----------------------------------------------------------------------------
// tb_cyclic_encoder_7_4
// Self-checking bench for cyclic_encoder_7_4. Accepted messages push their
// expected codeword bits (from a polynomial-division model) to a scoreboard
// queue; every serial transfer pops and compares one bit and its last flag.
// -----------------------------------------------------------------------------
module tb_cyclic_encoder_7_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] msg_data;
  logic       msg_valid;
  logic       msg_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_ready;
  logic       sout_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0]  sb[$];
  logic [13:0] cap;
  int          nxfer;
  logic [6:0]  mon_cw;
  logic [1:0]  mon_e;

  cyclic_encoder_7_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codeword by long division of m(x)*x^3 by g(x) = x^3 + x + 1.
  function automatic logic [6:0] model_cw(input logic [3:0] m);
    logic [6:0] r;
    logic [6:0] g;
    r = {m, 3'b000};
    g = 7'b0001011;
    for (int i = 6; i >= 3; i--) begin
      if (r[i]) r = r ^ (g << (i - 3));
    end
    return {m, r[2:0]};
  endfunction

  // Scoreboard: pop/compare on each transfer, push on each acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sout_valid && sout_ready) begin
        check("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sout_bit", 16'(sout), 16'(mon_e[0]));
          check("sout_last", 16'(sout_last), 16'(mon_e[1]));
        end
        cap   = {cap[12:0], sout};
        nxfer = nxfer + 1;
      end
      if (msg_valid && msg_ready) begin
        mon_cw = model_cw(msg_data);
        for (int i = 6; i >= 0; i--) begin
          sb.push_back({(i == 0) ? 1'b1 : 1'b0, mon_cw[i]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic accept_msg(input logic [3:0] m);
    logic ok;
    ok = 1'b0;
    msg_data  = m;
    msg_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (msg_ready) ok = 1'b1;
    end
    check("accept_timeout", 16'(ok), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    check("drain_timeout", 16'(ok), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [3:0] m, input logic [6:0] exp_word, input string tag);
    cap   = 14'd0;
    nxfer = 0;
    accept_msg(m);
    msg_valid = 1'b0;
    check({tag, "_latency_valid"}, 16'(sout_valid), 16'd1);
    check({tag, "_latency_bit"}, 16'(sout), 16'(m[3]));
    drain();
    check({tag, "_word"}, 16'(cap[6:0]), 16'(exp_word));
    check({tag, "_count"}, 16'(nxfer), 16'd7);
  endtask

  logic [2:0] snap_s;
  logic [2:0] prev_s;
  logic       prev_stalled;

  initial begin
    rst_n      = 1'b0;
    msg_data   = 4'b0000;
    msg_valid  = 1'b0;
    sout_ready = 1'b1;
    cap        = 14'd0;
    nxfer      = 0;

    // Reset state
    #3;
    check("rst_sout_valid", 16'(sout_valid), 16'd0);
    check("rst_sout", 16'(sout), 16'd0);
    check("rst_sout_last", 16'(sout_last), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_msg_ready", 16'(msg_ready), 16'd1);
    check("post_rst_sout_valid", 16'(sout_valid), 16'd0);
    @(posedge clk);
    #1;

    // Single codewords
    run_one(4'b1000, 7'b1000101, "m1000");
    run_one(4'b0001, 7'b0001011, "m0001");
    run_one(4'b1111, 7'b1111111, "m1111");
    run_one(4'b0000, 7'b0000000, "m0000");

    // Back-to-back codewords with msg_valid held
    cap   = 14'd0;
    nxfer = 0;
    accept_msg(4'b1000);
    msg_data = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("b2b_valid", 16'(sout_valid), 16'd1);
      if (i == 6) begin
        check("b2b_last", 16'(sout_last), 16'd1);
        check("b2b_ready_on_last", 16'(msg_ready), 16'd1);
      end
      @(posedge clk);
      #1;
      if (i == 6) msg_valid = 1'b0;
    end
    drain();
    check("b2b_word", 16'(cap), 16'({7'b1000101, 7'b0001011}));
    check("b2b_count", 16'(nxfer), 16'd14);

    // Random backpressure
    cap          = 14'd0;
    nxfer        = 0;
    prev_stalled = 1'b0;
    prev_s       = 3'b000;
    accept_msg(4'b1000);
    msg_valid = 1'b0;
    for (int i = 0; i < 150 && busy; i++) begin
      sout_ready = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      snap_s = {sout, sout_last, sout_valid};
      if (prev_stalled) check("stall_hold", 16'(snap_s), 16'(prev_s));
      prev_s       = snap_s;
      prev_stalled = !sout_ready;
      @(posedge clk);
      #1;
    end
    sout_ready = 1'b1;
    drain();
    check("stall_word", 16'(cap[6:0]), 16'(7'b1000101));
    check("stall_count", 16'(nxfer), 16'd7);

    // Reset in the middle of a codeword
    cap   = 14'd0;
    nxfer = 0;
    accept_msg(4'b1111);
    msg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sout_valid", 16'(sout_valid), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_sout", 16'(sout), 16'd0);
    check("midrst_sout_last", 16'(sout_last), 16'd0);
    check("midrst_bits_sent", 16'(nxfer), 16'd3);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_residue", 16'(sout_valid), 16'd0);
      check("midrst_msg_ready", 16'(msg_ready), 16'd1);
    end
    @(posedge clk);
    #1;
    run_one(4'b0001, 7'b0001011, "after_rst");

    check("sb_final_empty", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
